// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, RV64 word-op classification and the
// writeback queue entry format.
package alu_pkg;

  localparam int XLEN     = 64;
  localparam int RF_AW    = 5;
  localparam int OP_WIDTH = 6;

  // 6-bit ALU op codes; W variants occupy 0x16-0x1E and 0x27-0x2B.
  typedef enum logic [OP_WIDTH-1:0] {
    ALU_NOP   = 6'h00,
    ALU_ADD   = 6'h0C,
    ALU_SUB   = 6'h0D,
    ALU_SLL   = 6'h0E,
    ALU_SRL   = 6'h0F,
    ALU_SRA   = 6'h10,
    ALU_ADDIW = 6'h16,
    ALU_SLLIW = 6'h17,
    ALU_SRLIW = 6'h18,
    ALU_SRAIW = 6'h19,
    ALU_ADDW  = 6'h1A,
    ALU_SUBW  = 6'h1B,
    ALU_SLLW  = 6'h1C,
    ALU_SRLW  = 6'h1D,
    ALU_SRAW  = 6'h1E,
    ALU_MULW  = 6'h27,
    ALU_DIVW  = 6'h28,
    ALU_DIVUW = 6'h29,
    ALU_REMW  = 6'h2A,
    ALU_REMUW = 6'h2B
  } alu_op_e;

  // Writeback controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PRINT = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  // One queued register-file write.
  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

  // True for ops whose result is a 32-bit value that must be sign-extended.
  function automatic logic is_word_op(input logic [OP_WIDTH-1:0] op);
    return ((op >= 6'h16) && (op <= 6'h1E)) || ((op >= 6'h27) && (op <= 6'h2B));
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous result queue between the ALU and the register-file write port.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_push,
  input  wb_entry_t i_push_data,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  // Storage array; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy tracking; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: sign-extends W-op results, queues them, drives the
// shared register-file write port and sequences the end-of-cycle drain/print.
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = XLEN,
  parameter int FIFO_DEPTH     = 4,
  parameter int RF_ADDR_WIDTH  = RF_AW
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BUS_DATA_WIDTH-1:0] in_data,
  input  logic [5:0]                in_alu_control,
  input  logic [RF_ADDR_WIDTH-1:0]  in_rd,
  output logic                      rf_wr_en,
  output logic [RF_ADDR_WIDTH-1:0]  rf_wr_addr,
  output logic [BUS_DATA_WIDTH-1:0] rf_wr_data,
  input  logic                      rf_wr_grant,
  input  logic                      end_of_cycle,
  output logic                      send_call_for_print,
  output logic [31:0]               retire_count
);

  wb_state_e                 r_state;
  wb_state_e                 w_next_state;
  logic [31:0]               r_retire_count;
  logic                      w_accept;
  logic                      w_rd_zero;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [BUS_DATA_WIDTH-1:0] w_fmt_data;
  wb_entry_t                 w_push_entry;
  wb_entry_t                 w_head;

  // Ready is masked by reset so the port reads not-ready while reset is held.
  assign in_ready  = reset_n && (r_state == ST_IDLE) && !w_full;
  assign w_accept  = in_valid && in_ready;
  assign w_rd_zero = (in_rd == '0);
  assign w_push    = w_accept && !w_rd_zero;
  assign w_pop     = !w_empty && rf_wr_grant;

  // Word ops produce 32-bit results that are sign-extended to the full width.
  always_comb begin
    w_fmt_data = in_data;
    if (is_word_op(in_alu_control)) begin
      w_fmt_data = {{(BUS_DATA_WIDTH-32){in_data[31]}}, in_data[31:0]};
    end
    w_push_entry      = '0;
    w_push_entry.rd   = in_rd;
    w_push_entry.data = w_fmt_data;
  end

  wb_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_push),
    .i_push_data(w_push_entry),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Write port mirrors the queue head; zeroed when idle so stale storage never leaks out.
  assign rf_wr_en   = !w_empty;
  assign rf_wr_addr = w_empty ? '0 : w_head.rd;
  assign rf_wr_data = w_empty ? '0 : w_head.data;

  // Retire counter: rd==0 drops count on accept, real writes count on pop; wraps freely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retire_count <= '0;
    end else begin
      r_retire_count <= r_retire_count
                      + {31'b0, (w_accept && w_rd_zero)}
                      + {31'b0, w_pop};
    end
  end

  assign retire_count = r_retire_count;

  // Controller state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Drain sequencing: wait for an empty queue, pulse print once, hold until end_of_cycle drops.
  always_comb begin
    w_next_state        = r_state;
    send_call_for_print = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (end_of_cycle) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_empty) begin
          w_next_state = ST_PRINT;
        end
      end
      ST_PRINT: begin
        send_call_for_print = 1'b1;
        w_next_state        = ST_DONE;
      end
      ST_DONE: begin
        if (!end_of_cycle) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage.
module tb_alu_writeback_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [5:0]  in_alu_control;
  logic [4:0]  in_rd;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [63:0] rf_wr_data;
  logic        rf_wr_grant;
  logic        end_of_cycle;
  logic        send_call_for_print;
  logic [31:0] retire_count;

  int total;
  int bad;

  alu_writeback_stage #(
    .BUS_DATA_WIDTH(64),
    .FIFO_DEPTH    (4),
    .RF_ADDR_WIDTH (5)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .in_alu_control     (in_alu_control),
    .in_rd              (in_rd),
    .rf_wr_en           (rf_wr_en),
    .rf_wr_addr         (rf_wr_addr),
    .rf_wr_data         (rf_wr_data),
    .rf_wr_grant        (rf_wr_grant),
    .end_of_cycle       (end_of_cycle),
    .send_call_for_print(send_call_for_print),
    .retire_count       (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one input beat without waiting.
  task automatic drive(input logic v, input logic [5:0] op, input logic [63:0] d, input logic [4:0] rd);
    in_valid       = v;
    in_alu_control = op;
    in_data        = d;
    in_rd          = rd;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    rf_wr_grant  = 1'b0;
    end_of_cycle = 1'b0;
    drive(1'b0, 6'h00, 64'h0, 5'd0);
    #3;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0h want=0", in_ready); end
    total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%0h want=0", rf_wr_en); end
    total++; if (rf_wr_addr !== 5'd0) begin bad++; $display("FAIL reset_wr_addr got=%0h want=0", rf_wr_addr); end
    total++; if (rf_wr_data !== 64'h0) begin bad++; $display("FAIL reset_wr_data got=%0h want=0", rf_wr_data); end
    total++; if (send_call_for_print !== 1'b0) begin bad++; $display("FAIL reset_print got=%0h want=0", send_call_for_print); end
    total++; if (retire_count !== 32'd0) begin bad++; $display("FAIL reset_retire got=%0d want=0", retire_count); end
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0h want=1", in_ready); end
  endtask

  task automatic test_word_op();
    rf_wr_grant = 1'b1;
    drive(1'b1, 6'h1A, 64'h0000_0000_8000_0001, 5'd5);
    tick();
    drive(1'b0, 6'h00, 64'h0, 5'd0);
    total++; if (rf_wr_en !== 1'b1) begin bad++; $display("FAIL addw_wr_en got=%0h want=1", rf_wr_en); end
    total++; if (rf_wr_addr !== 5'd5) begin bad++; $display("FAIL addw_addr got=%0d want=5", rf_wr_addr); end
    total++; if (rf_wr_data !== 64'hFFFF_FFFF_8000_0001) begin bad++; $display("FAIL addw_data got=%0h want=ffffffff80000001", rf_wr_data); end
    total++; if (retire_count !== 32'd0) begin bad++; $display("FAIL addw_retire_pre got=%0d want=0", retire_count); end
    tick();
    total++; if (retire_count !== 32'd1) begin bad++; $display("FAIL addw_retire got=%0d want=1", retire_count); end
    total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL addw_empty got=%0h want=0", rf_wr_en); end
  endtask

  task automatic test_plain_op();
    rf_wr_grant = 1'b1;
    drive(1'b1, 6'h0C, 64'h0000_0000_8000_0001, 5'd7);
    tick();
    drive(1'b0, 6'h00, 64'h0, 5'd0);
    total++; if (rf_wr_addr !== 5'd7) begin bad++; $display("FAIL add_addr got=%0d want=7", rf_wr_addr); end
    total++; if (rf_wr_data !== 64'h0000_0000_8000_0001) begin bad++; $display("FAIL add_data got=%0h want=80000001", rf_wr_data); end
    tick();
    total++; if (retire_count !== 32'd2) begin bad++; $display("FAIL add_retire got=%0d want=2", retire_count); end
  endtask

  task automatic test_fill_hold();
    rf_wr_grant = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 6'h0C, 64'(256 + i), 5'(i));
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_%0d got=%0h want=1", i, in_ready); end
      tick();
    end
    drive(1'b0, 6'h00, 64'h0, 5'd0);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0h want=0", in_ready); end
    tick();
    total++; if (rf_wr_addr !== 5'd1) begin bad++; $display("FAIL hold_addr got=%0d want=1", rf_wr_addr); end
    total++; if (rf_wr_data !== 64'h101) begin bad++; $display("FAIL hold_data got=%0h want=101", rf_wr_data); end
    total++; if (retire_count !== 32'd2) begin bad++; $display("FAIL hold_retire got=%0d want=2", retire_count); end
    rf_wr_grant = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++; if (rf_wr_addr !== 5'(i) || rf_wr_data !== 64'(256 + i) || rf_wr_en !== 1'b1) begin
        bad++; $display("FAIL drain_order_%0d got=%0d/%0h want=%0d/%0h", i, rf_wr_addr, rf_wr_data, i, 256 + i);
      end
      tick();
      if (i == 1) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_pop got=%0h want=1", in_ready); end
      end
    end
    total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL fill_empty got=%0h want=0", rf_wr_en); end
    total++; if (retire_count !== 32'd6) begin bad++; $display("FAIL fill_retire got=%0d want=6", retire_count); end
  endtask

  task automatic test_rd_zero();
    rf_wr_grant = 1'b1;
    drive(1'b1, 6'h1A, 64'h99, 5'd0);
    tick();
    drive(1'b0, 6'h00, 64'h0, 5'd0);
    total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL rd0_wr_en got=%0h want=0", rf_wr_en); end
    total++; if (retire_count !== 32'd7) begin bad++; $display("FAIL rd0_retire got=%0d want=7", retire_count); end
  endtask

  task automatic test_dual_retire();
    rf_wr_grant = 1'b0;
    drive(1'b1, 6'h0C, 64'h33, 5'd3);
    tick();
    total++; if (retire_count !== 32'd7) begin bad++; $display("FAIL dual_pre_retire got=%0d want=7", retire_count); end
    drive(1'b1, 6'h0C, 64'h55, 5'd0);
    rf_wr_grant = 1'b1;
    tick();
    drive(1'b0, 6'h00, 64'h0, 5'd0);
    total++; if (retire_count !== 32'd9) begin bad++; $display("FAIL dual_retire got=%0d want=9", retire_count); end
    total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL dual_empty got=%0h want=0", rf_wr_en); end
  endtask

  task automatic test_drain_print();
    rf_wr_grant = 1'b0;
    drive(1'b1, 6'h0C, 64'h88, 5'd8);
    tick();
    drive(1'b1, 6'h0C, 64'h99, 5'd9);
    tick();
    drive(1'b0, 6'h00, 64'h0, 5'd0);
    end_of_cycle = 1'b1;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL drain_ready got=%0h want=0", in_ready); end
    total++; if (send_call_for_print !== 1'b0) begin bad++; $display("FAIL drain_print_early got=%0h want=0", send_call_for_print); end
    tick();
    tick();
    total++; if (rf_wr_addr !== 5'd8 || send_call_for_print !== 1'b0) begin bad++; $display("FAIL drain_hold got=%0d/%0h want=8/0", rf_wr_addr, send_call_for_print); end
    rf_wr_grant = 1'b1;
    tick();
    total++; if (rf_wr_addr !== 5'd9 || send_call_for_print !== 1'b0) begin bad++; $display("FAIL drain_second got=%0d/%0h want=9/0", rf_wr_addr, send_call_for_print); end
    tick();
    total++; if (rf_wr_en !== 1'b0 || send_call_for_print !== 1'b0) begin bad++; $display("FAIL drain_done got=%0h/%0h want=0/0", rf_wr_en, send_call_for_print); end
    tick();
    total++; if (send_call_for_print !== 1'b1) begin bad++; $display("FAIL print_pulse got=%0h want=1", send_call_for_print); end
    tick();
    total++; if (send_call_for_print !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL print_single got=%0h/%0h want=0/0", send_call_for_print, in_ready); end
    tick();
    total++; if (send_call_for_print !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL done_hold got=%0h/%0h want=0/0", send_call_for_print, in_ready); end
    end_of_cycle = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL done_release got=%0h want=1", in_ready); end
    total++; if (retire_count !== 32'd11) begin bad++; $display("FAIL drain_retire got=%0d want=11", retire_count); end
  endtask

  task automatic test_accept_at_eoc();
    rf_wr_grant  = 1'b1;
    end_of_cycle = 1'b1;
    drive(1'b1, 6'h0C, 64'h44, 5'd4);
    tick();
    drive(1'b0, 6'h00, 64'h0, 5'd0);
    total++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL eoc_accept got=%0h/%0d/%0h want=1/4/0", rf_wr_en, rf_wr_addr, in_ready); end
    tick();
    total++; if (rf_wr_en !== 1'b0 || send_call_for_print !== 1'b0) begin bad++; $display("FAIL eoc_pop got=%0h/%0h want=0/0", rf_wr_en, send_call_for_print); end
    tick();
    total++; if (send_call_for_print !== 1'b1) begin bad++; $display("FAIL eoc_print got=%0h want=1", send_call_for_print); end
    tick();
    total++; if (send_call_for_print !== 1'b0) begin bad++; $display("FAIL eoc_print_end got=%0h want=0", send_call_for_print); end
    end_of_cycle = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1 || retire_count !== 32'd12) begin bad++; $display("FAIL eoc_release got=%0h/%0d want=1/12", in_ready, retire_count); end
  endtask

  task automatic test_empty_drain();
    end_of_cycle = 1'b1;
    tick();
    total++; if (send_call_for_print !== 1'b0) begin bad++; $display("FAIL empty_drain_cycle got=%0h want=0", send_call_for_print); end
    tick();
    total++; if (send_call_for_print !== 1'b1) begin bad++; $display("FAIL empty_print got=%0h want=1", send_call_for_print); end
    tick();
    total++; if (send_call_for_print !== 1'b0) begin bad++; $display("FAIL empty_print_end got=%0h want=0", send_call_for_print); end
    end_of_cycle = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL empty_release got=%0h want=1", in_ready); end
  endtask

  task automatic test_async_reset();
    rf_wr_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'h0C, 64'(16'hA0 + i), 5'(10 + i));
      tick();
    end
    drive(1'b0, 6'h00, 64'h0, 5'd0);
    total++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd10) begin bad++; $display("FAIL prereset_queue got=%0h/%0d want=1/10", rf_wr_en, rf_wr_addr); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== 64'h0) begin bad++; $display("FAIL areset_port got=%0h/%0d/%0h want=0/0/0", rf_wr_en, rf_wr_addr, rf_wr_data); end
    total++; if (retire_count !== 32'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL areset_state got=%0d/%0h want=0/0", retire_count, in_ready); end
    tick();
    reset_n = 1'b1;
    #1;
    total++; if (rf_wr_en !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL postreset got=%0h/%0h want=0/1", rf_wr_en, in_ready); end
    tick();
    total++; if (rf_wr_en !== 1'b0 || retire_count !== 32'd0) begin bad++; $display("FAIL postreset_empty got=%0h/%0d want=0/0", rf_wr_en, retire_count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_word_op();
    test_plain_op();
    test_fill_hold();
    test_rd_zero();
    test_dual_retire();
    test_drain_print();
    test_accept_at_eoc();
    test_empty_drain();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
